// File: rtl/bin_to_bcd_converter_if.sv
// bin_to_bcd_converter_if
// Handshake and data bundle for bin_to_bcd_converter.
//   start    : request a conversion (master -> converter)
//   bin_in   : WIDTH-bit unsigned operand (master -> converter)
//   busy     : conversion in progress (converter -> master)
//   done     : one-cycle pulse, new bcd_out/overflow valid (converter -> master)
//   bcd_out  : DIGITS packed BCD nibbles, units in [3:0] (converter -> master)
//   overflow : last result exceeded 10^DIGITS-1 (converter -> master)
interface bin_to_bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter
// Sequential shift-and-add-3 (double dabble) binary to packed BCD converter,
// one input bit per clock. Feeds per-digit 7-segment decoders.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bin_to_bcd_converter_if.slave (start, bin_in, busy, done,
//           bcd_out, overflow)
// Parameters: WIDTH (1..16) input bits, DIGITS (1..5) output digits.
// Build option: define BCD_BLANK_EN to drive leading-zero digits (above
// digit 0) as 4'hF so the downstream decoders blank them.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// SHIFT | one add-3/shift iteration per cycle, WIDTH cycles
// DONE  | result registered, done=1 for one cycle
module bin_to_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bin_to_bcd_converter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] shreg, sh_nxt;
  logic [BW-1:0]   scratch, adj, scr_nxt, bcd_load;
  logic [BW-1:0]   bcd_r;
  logic [CW-1:0]   cnt;
  logic            ovf_acc, ovf_nxt, carry, overflow_r;
  logic            last_shift;

  assign last_shift = (cnt == CW'(1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b1;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Add 3 to every digit >= 5 before the shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // carry is the bit leaving the top digit; it marks a value >= 10^DIGITS
  assign {carry, scr_nxt, sh_nxt} = {adj, shreg, 1'b0};
  assign ovf_nxt = ovf_acc | carry;

`ifdef BCD_BLANK_EN
  function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] v);
    logic lead;
    blank_lead = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) blank_lead[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
  endfunction

  assign bcd_load = blank_lead(scr_nxt);
`else
  assign bcd_load = scr_nxt;
`endif

  // Datapath; result registers load on the last shift so they are
  // visible together with done in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      bcd_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.bin_in;
            scratch <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          shreg   <= sh_nxt;
          scratch <= scr_nxt;
          ovf_acc <= ovf_nxt;
          cnt     <= cnt - CW'(1);
          if (last_shift) begin
            bcd_r      <= bcd_load;
            overflow_r <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd_out  = bcd_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
module tb_bin_to_bcd_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) bus3 ();
  bin_to_bcd_converter_if #(.WIDTH(8), .DIGITS(2)) bus2 ();

  bin_to_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave)
  );
  bin_to_bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  typedef struct {
    int         sel;   // 0: 3-digit DUT, 1: 2-digit DUT
    logic [7:0] bin;
    logic [11:0] exp;  // unblanked expected BCD
    logic       ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected output after optional leading-zero blanking
  function automatic logic [11:0] expect_bcd(input logic [11:0] v, input int digits);
    logic [11:0] r;
    logic lead;
    r = v;
`ifdef BCD_BLANK_EN
    lead = 1'b1;
    for (int i = digits - 1; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
    if (lead) r = 12'h0;
`endif
    if (digits == 2) r[11:8] = 4'h0;
    return r;
  endfunction

  function automatic logic get_done(input int sel);
    return sel == 0 ? bus3.done : bus2.done;
  endfunction
  function automatic logic get_busy(input int sel);
    return sel == 0 ? bus3.busy : bus2.busy;
  endfunction
  function automatic logic [11:0] get_bcd(input int sel);
    return sel == 0 ? bus3.bcd_out : {4'h0, bus2.bcd_out};
  endfunction
  function automatic logic get_ovf(input int sel);
    return sel == 0 ? bus3.overflow : bus2.overflow;
  endfunction

  // One conversion: start pulse, wait for done (bounded), check handshake
  task automatic run_conv(input int sel, input logic [7:0] v, input logic [11:0] prev,
                          output logic [11:0] bcd, output logic ovf, output int lat);
    bit busy_ok, held_ok;
    @(negedge clk);
    if (sel == 0) begin bus3.start = 1'b1; bus3.bin_in = v; end
    else          begin bus2.start = 1'b1; bus2.bin_in = v; end
    @(posedge clk); #1;
    // drop start and disturb bin_in; neither may affect the result
    if (sel == 0) begin bus3.start = 1'b0; bus3.bin_in = ~v; end
    else          begin bus2.start = 1'b0; bus2.bin_in = ~v; end
    lat = 0; busy_ok = 1'b1; held_ok = 1'b1;
    while (!get_done(sel) && lat < 40) begin
      if (!get_busy(sel)) busy_ok = 1'b0;
      if (get_bcd(sel) !== prev) held_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) begin
      tests++; fails++;
      $display("FAIL timeout: no done within 40 cycles for bin %0d", v);
    end
    check("busy_during", {31'b0, busy_ok}, 32'd1);
    check("bcd_held", {31'b0, held_ok}, 32'd1);
    check("busy_in_done", {31'b0, get_busy(sel)}, 32'd1);
    bcd = get_bcd(sel);
    ovf = get_ovf(sel);
    @(posedge clk); #1;
    check("done_one_cycle", {30'b0, get_done(sel), get_busy(sel)}, 32'd0);
  endtask

  initial begin
    logic [11:0] bcd, prev3, prev2, exp;
    logic ovf;
    int lat, ndone, first_c, last_c;

    vecs[0]  = '{0, 8'hFF, 12'h255, 1'b0};
    vecs[1]  = '{0, 8'd0,  12'h000, 1'b0};
    vecs[2]  = '{0, 8'd7,  12'h007, 1'b0};
    vecs[3]  = '{0, 8'd42, 12'h042, 1'b0};
    vecs[4]  = '{0, 8'd100, 12'h100, 1'b0};
    vecs[5]  = '{0, 8'd10, 12'h010, 1'b0};
    vecs[6]  = '{0, 8'd128, 12'h128, 1'b0};
    vecs[7]  = '{0, 8'd99, 12'h099, 1'b0};
    vecs[8]  = '{0, 8'd1,  12'h001, 1'b0};
    vecs[9]  = '{1, 8'd100, 12'h000, 1'b1};
    vecs[10] = '{1, 8'd99, 12'h099, 1'b0};
    vecs[11] = '{1, 8'd255, 12'h055, 1'b1};
    vecs[12] = '{1, 8'd250, 12'h050, 1'b1};
    vecs[13] = '{1, 8'd9,  12'h009, 1'b0};

    bus3.start = 1'b0; bus3.bin_in = '0;
    bus2.start = 1'b0; bus2.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs3", {bus3.busy, bus3.done, bus3.overflow, 17'b0, bus3.bcd_out}, 32'd0);
    check("reset_outputs2", {bus2.busy, bus2.done, bus2.overflow, 21'b0, bus2.bcd_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    prev3 = 12'h0; prev2 = 12'h0;
    foreach (vecs[k]) begin
      exp = expect_bcd(vecs[k].exp, vecs[k].sel == 0 ? 3 : 2);
      run_conv(vecs[k].sel, vecs[k].bin, vecs[k].sel == 0 ? prev3 : prev2, bcd, ovf, lat);
      check($sformatf("bcd[%0d]", k), {20'b0, bcd}, {20'b0, exp});
      check($sformatf("ovf[%0d]", k), {31'b0, ovf}, {31'b0, vecs[k].ovf});
      check($sformatf("latency[%0d]", k), lat, 8);
      if (vecs[k].sel == 0) prev3 = exp; else prev2 = exp;
    end

    // start during conversion is ignored
    @(negedge clk); bus3.start = 1'b1; bus3.bin_in = 8'd42;
    @(posedge clk); #1; bus3.start = 1'b0;
    ndone = 0; bcd = 12'h0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin bus3.start = 1'b1; bus3.bin_in = 8'd200; end
      @(posedge clk); #1;
      bus3.start = 1'b0;
      if (bus3.done) begin
        ndone++;
        if (ndone == 1) begin
          bcd = bus3.bcd_out;
          check("ignore_latency", c, 8);
        end
      end
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_bcd", {20'b0, bcd}, {20'b0, expect_bcd(12'h042, 3)});

    // asynchronous reset mid-conversion
    @(negedge clk); bus3.start = 1'b1; bus3.bin_in = 8'd123;
    @(posedge clk); #1; bus3.start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check("async_reset", {bus3.busy, bus3.done, bus3.overflow, 17'b0, bus3.bcd_out}, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_conv(0, 8'd123, 12'h000, bcd, ovf, lat);
    check("after_reset_bcd", {20'b0, bcd}, {20'b0, expect_bcd(12'h123, 3)});
    check("after_reset_lat", lat, 8);

    // start held high: one result every WIDTH+2 cycles
    @(negedge clk); bus3.start = 1'b1; bus3.bin_in = 8'd58;
    @(posedge clk); #1;
    ndone = 0; first_c = -1; last_c = -1;
    for (int c = 1; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus3.done) begin
        if (ndone > 0) check("held_period", c - last_c, 10);
        else first_c = c;
        check("held_bcd", {20'b0, bus3.bcd_out}, {20'b0, expect_bcd(12'h058, 3)});
        last_c = c;
        ndone++;
      end
    end
    bus3.start = 1'b0;
    check("held_first", first_c, 8);
    check("held_count", ndone, 3);
    repeat (12) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
